// File: rtl/breg_pkg.sv
// Shared types and defaults for the parametrised register bank.
package breg_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

endpackage

// File: rtl/breg_multiport_if.sv
// Register-bank bus: one write port, NRD flattened read ports, status flags.
interface breg_multiport_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2
);

  logic                  clr_req;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  busy;
  logic                  wr_drop;

  modport master (
    output clr_req, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, busy, wr_drop
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, busy, wr_drop
  );

endinterface

// File: rtl/breg_rd_port.sv
// One combinational read port: array mux, zero-register and busy masking,
// optional write-through forwarding when BREG_BYPASS_EN is defined.
module breg_rd_port
  import breg_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [DATA_W-1:0] mem [2**ADDR_W],
  input  logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

`ifndef BREG_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  // Masks are applied last so they also cover the forwarded value:
  // busy implies not IDLE, and a zero-register write is never forwarded.
  always_comb begin
    rd_data = mem[rd_addr];
`ifdef BREG_BYPASS_EN
    if (wr_en && (rd_addr == wr_addr)) begin
      rd_data = wr_data;
    end
`endif
    if (busy || ((ZERO_REG != 0) && (rd_addr == '0))) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/breg_multiport.sv
// Parametrised multi-read-port register bank with a sequential clear sweep
// after reset or on request. Optional feature macro: BREG_BYPASS_EN.
module breg_multiport
  import breg_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input logic             clk,
  input logic             rst,
  breg_multiport_if.slave bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              drop_q;
  logic              wr_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  assign wr_ok = bus.wr_en && (state == ST_IDLE) &&
                 !((ZERO_REG != 0) && (bus.wr_addr == '0));

  // Sweep FSM, sweep pointer and registered dropped-write flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_CLEAR;
      ptr    <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= bus.wr_en && (state == ST_CLEAR);
      case (state)
        ST_IDLE: begin
          if (bus.clr_req) begin
            state <= ST_CLEAR;
            ptr   <= '0;
          end
        end
        ST_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Storage is not reset; the sweep zeroes it. A write coinciding with
  // clr_req lands here first and is wiped later by the sweep.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.busy    = (state == ST_CLEAR);
  assign bus.wr_drop = drop_q;

  // Independent read ports.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    breg_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .mem     (mem),
      .busy    (bus.busy),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_addr (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .rd_data (bus.rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_breg_multiport.sv
// Directed self-checking bench for breg_multiport (DATA_W=32, ADDR_W=5, NRD=2).
module tb_breg_multiport;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  int   n;

  breg_multiport_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus ();

  breg_multiport #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NRD      (2),
    .ZERO_REG (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while ((bus.busy === 1'b1) && (cyc < 100)) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  function automatic logic [31:0] rd0();
    return bus.rd_data[31:0];
  endfunction

  function automatic logic [31:0] rd1();
    return bus.rd_data[63:32];
  endfunction

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    bus.clr_req = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = {5'd0, 5'd7};

    // 1. reset and initial sweep
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd1);
    chk("rst_drop", {31'd0, bus.wr_drop}, 32'd0);
    chk("rst_rd0_masked", rd0(), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rel_busy", {31'd0, bus.busy}, 32'd1);
    wait_idle(n);
    chk("sweep_len", n, 32'd32);
    chk("post_busy", {31'd0, bus.busy}, 32'd0);
    chk("rd0_addr7", rd0(), 32'd0);

    // 2. two writes, simultaneous read on both ports
    wr(5'd3, 32'h0000_00AA);
    wr(5'd5, 32'h0000_1234);
    bus.rd_addr = {5'd5, 5'd3};
    #1;
    chk("p0_addr3", rd0(), 32'h0000_00AA);
    chk("p1_addr5", rd1(), 32'h0000_1234);
    chk("wr_drop_idle", {31'd0, bus.wr_drop}, 32'd0);

    // 3. zero register ignores writes, no drop flag
    wr(5'd0, 32'hFFFF_FFFF);
    bus.rd_addr = {5'd0, 5'd0};
    #1;
    chk("zr_drop", {31'd0, bus.wr_drop}, 32'd0);
    chk("zr_p0", rd0(), 32'd0);
    chk("zr_p1", rd1(), 32'd0);

    // 6. read of a location on its write edge
    wr(5'd9, 32'h0000_0011);
    bus.rd_addr = {5'd3, 5'd9};
    #1;
    chk("pre_addr9", rd0(), 32'h0000_0011);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd9;
    bus.wr_data = 32'h0000_0055;
    #1;
`ifdef BREG_BYPASS_EN
    chk("same_cycle_addr9", rd0(), 32'h0000_0055);
`else
    chk("same_cycle_addr9", rd0(), 32'h0000_0011);
`endif
    chk("other_port_unaffected", rd1(), 32'h0000_00AA);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("after_edge_addr9", rd0(), 32'h0000_0055);

    // 4. clear request with a dropped write during the sweep
    wr(5'd4, 32'h0000_BEEF);
    bus.rd_addr = {5'd3, 5'd4};
    #1;
    chk("pre_addr4", rd0(), 32'h0000_BEEF);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    #1;
    chk("clr_busy", {31'd0, bus.busy}, 32'd1);
    chk("clr_rd1_masked", rd1(), 32'd0);
    tick();
    tick();
    wr(5'd4, 32'h0000_0077);
    #1;
    chk("drop_pulse", {31'd0, bus.wr_drop}, 32'd1);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    #1;
    chk("drop_end", {31'd0, bus.wr_drop}, 32'd0);
    wait_idle(n);
    chk("clr_sweep_rest", n, 32'd28);
    #1;
    chk("addr4_cleared", rd0(), 32'd0);
    chk("addr3_cleared", rd1(), 32'd0);

    // 5. reset mid-sweep restarts it; write+clr_req same edge gets cleared
    wr(5'd8, 32'h0000_0088);
    bus.rd_addr = {5'd6, 5'd8};
    #1;
    chk("pre_addr8", rd0(), 32'h0000_0088);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd6;
    bus.wr_data = 32'h0000_0066;
    bus.clr_req = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
    bus.clr_req = 1'b0;
    #1;
    chk("wc_drop", {31'd0, bus.wr_drop}, 32'd0);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    tick();
    rst = 1'b0;
    wait_idle(n);
    chk("restart_len", n, 32'd32);
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr = {5'(i + 16), 5'(i)};
      #1;
      chk($sformatf("final_p0_%0d", i), rd0(), 32'd0);
      chk($sformatf("final_p1_%0d", i + 16), rd1(), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
